uart_burst_tx: RTL and testbench
================================

Name: uart_burst_tx

Overview:
- Parametrised successor of the push-button character-pair UART sender.
- On each start request it frames a burst of N alternating characters (all-zeros, all-ones, all-zeros, ...) onto txd and brackets the burst with rts.
- Fully synchronous: one clk domain, with the baud rate produced as a clock-enable tick rather than a derived clock.
- Adds configurable burst length, 5..8 data bits, optional even/odd parity, an RTS lead time, and busy/done status for the surrounding board top.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD_LO, 2400, baud rate when baud_sel=0.
- BAUD_HI, 9600, baud rate when baud_sel=1.
- CNT_W, 4, width of burst_len; maximum burst is 2^CNT_W-1 characters.
- RTS_LEAD, 1, number of idle bit-times (txd=1, rts=1) before the first start bit; range 0..3.

Ports:
- clk  in  1  system clock; every flop is clocked by it.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  burst request (button level, asynchronous); the rising edge is used.
- baud_sel  in  1  0=BAUD_LO, 1=BAUD_HI.
- data_bits  in  2  character length minus 5 (0..3 selects 5..8 bits).
- stop2  in  1  0=one stop bit, 1=two stop bits.
- parity_en  in  1  1=append a parity bit.
- parity_odd  in  1  0=even parity, 1=odd parity.
- burst_len  in  CNT_W  number of characters per burst.
- rts  out  1  1=ON; high from LEAD through the last stop bit.
- txd  out  1  serial line; idle/mark=1.
- busy  out  1  high while not IDLE.
- done  out  1  one-clk pulse at burst completion.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - txd=1, rts=0, busy=0, done=0.
  - FSM=IDLE; all counters and synchronisers cleared.
  - A reset mid-frame aborts the burst immediately; no partial stop bit is emitted.
- Start detection:
  - start passes through a 2-flop synchroniser, then an edge register.
  - A request is the one-clk pulse on 0->1 of the synchronised signal.
  - Requests while busy=1 are discarded and are not queued.
  - A request with burst_len=0 is ignored: no rts, no done.
- Configuration latch: on an accepted request, baud_sel, data_bits, stop2, parity_en, parity_odd and burst_len are captured. Input changes during a burst have no effect.
- Baud tick:
  - DIV = round(CLK_HZ/BAUD); at defaults, 20833 (2400) and 5208 (9600).
  - The divider is held at 0 in IDLE, so every bit lasts exactly DIV clks.
  - tick pulses when count = DIV-1; the count then wraps to 0.
- FSM (transitions on tick unless noted):
  - IDLE: on accepted request go to LEAD, or to START if RTS_LEAD=0. rts and busy rise on the clk after the request pulse.
  - LEAD: txd=1 for RTS_LEAD bit-times, then START.
  - START: txd=0 for 1 bit-time, then DATA.
  - DATA: txd=pattern bit, LSB first, for 5..8 bit-times.
    - Pattern is all 0 for even character index (0,2,...) and all 1 for odd index.
    - Every burst begins at index 0.
  - PARITY (only if parity_en): txd = XOR of the data bits, inverted when parity_odd=1.
  - STOP: txd=1 for 1 or 2 bit-times.
    - If the character index+1 < latched burst_len: increment the index and go to START, with no inter-character gap.
    - Otherwise go to IDLE: rts=0, busy=0, and done=1 for one clk, all on the same edge.
- Frame length: 1 + (5..8) + parity_en + (1..2) bit-times per character.
- Widths:
  - Bit counter: 3 bits.
  - Character index: CNT_W bits; it cannot wrap, because burst_len ≤ 2^CNT_W-1.
  - Divider: clog2(max DIV) bits.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, LEAD, START, DATA, PARITY, STOP).
  - DATA_BITS_MIN=5.
  - Function div_of(clk_hz, baud) returning the rounded divider.
- One sub-module: uart_baud_tick (clk, rst, en, sel → tick), parametrised by CLK_HZ, BAUD_LO and BAUD_HI.
- The start synchroniser and FSM stay in uart_burst_tx.

Test Plan (bench CLK_HZ=96000, BAUD_LO=2400→DIV 40, BAUD_HI=9600→DIV 10, RTS_LEAD=1):
- Basic burst: baud_sel=1, data_bits=2 (7 bits), stop2=0, no parity, burst_len=2, one start pulse.
  - rts rises 3 clks after start's rising edge.
  - txd carries 10 clks high, then 0,0000000,1, then 0,1111111,1, each bit 10 clks.
  - rts falls and done pulses 190 clks after rts rose.
- Options: data_bits=3, stop2=1, parity_en=1, parity_odd=0, burst_len=3.
  - Frames are 0,00000000,0,11 / 0,11111111,0,11 / 0,00000000,0,11.
  - Repeat with parity_odd=1: parity bits become 1,1,1.
- Baud select: baud_sel=0 → every bit lasts 40 clks; burst_len=1, 5-bit frame (0,00000,1) gives rts high for 8×40=320 clks.
- Busy and ignore rules:
  - A second start edge mid-burst produces no extra characters and exactly one done pulse.
  - burst_len=0 → rts stays 0, no done.
  - Configuration inputs changed mid-burst → waveform unchanged.
- Reset mid-burst: drive rst=0 during a DATA bit of char 1 → txd=1, rts=0, busy=0 within the same cycle. After release, a new start gives a clean burst beginning with the all-zeros character.
- Held start: start held high for 1000 clks → exactly one burst; start low then high again after done → a second burst.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the burst UART transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS_MIN = 5;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  typedef struct packed {
    logic       baud_sel;
    logic [1:0] data_bits;
    logic       stop2;
    logic       parity_en;
    logic       parity_odd;
  } cfg_t;

  // Rounded clock divider for a given baud rate.
  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate clock enable: one-clk tick every DIV clks while enabled, held at 0 otherwise.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD_LO = 2400,
  parameter int unsigned BAUD_HI = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sel,
  output logic tick
);

  localparam int unsigned DIV_LO  = div_of(CLK_HZ, BAUD_LO);
  localparam int unsigned DIV_HI  = div_of(CLK_HZ, BAUD_HI);
  localparam int unsigned DIV_MAX = (DIV_LO > DIV_HI) ? DIV_LO : DIV_HI;
  localparam int unsigned DIV_W   = ($clog2(DIV_MAX) > 0) ? $clog2(DIV_MAX) : 1;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  assign last = sel ? DIV_W'(DIV_HI - 1) : DIV_W'(DIV_LO - 1);
  assign tick = en && (cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/uart_burst_tx.sv
// Burst UART sender: frames burst_len alternating all-0/all-1 characters per start edge,
// bracketed by rts with an optional lead-in of idle bit-times.
module uart_burst_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BAUD_LO  = 2400,
  parameter int unsigned BAUD_HI  = 9600,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned RTS_LEAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             baud_sel,
  input  logic [1:0]       data_bits,
  input  logic             stop2,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic [CNT_W-1:0] burst_len,
  output logic             rts,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  cfg_t             cfg_q;
  logic [CNT_W-1:0] len_q, idx, idx_n;
  logic [2:0]       bit_cnt, bit_n, last_data;
  logic [2:0]       start_sync;
  logic             req, load, tick, par_bit;
  logic             txd_n, rts_n, busy_n, done_n;

  // Two synchroniser flops followed by the edge register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_sync <= '0;
    else      start_sync <= {start_sync[1:0], start};
  end
  assign req = start_sync[1] & ~start_sync[2];

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD_LO(BAUD_LO),
    .BAUD_HI(BAUD_HI)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .sel (cfg_q.baud_sel),
    .tick(tick)
  );

  assign last_data = 3'(DATA_BITS_MIN - 1) + 3'(cfg_q.data_bits);
  // Character bits are uniform, so their XOR is the pattern bit when the length is odd.
  assign par_bit   = (idx_n[0] & ~cfg_q.data_bits[0]) ^ cfg_q.parity_odd;

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    idx_n   = idx;
    load    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (req && (burst_len != '0)) begin
          load    = 1'b1;
          idx_n   = '0;
          bit_n   = '0;
          state_n = (RTS_LEAD == 0) ? START : LEAD;
        end
      end
      LEAD: begin
        if (tick) begin
          if (bit_cnt == 3'(RTS_LEAD - 1)) begin
            state_n = START;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 3'(1);
          end
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == last_data) begin
            state_n = cfg_q.parity_en ? PARITY : STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 3'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          bit_n   = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == 3'(cfg_q.stop2)) begin
            bit_n = '0;
            if (idx < len_q - CNT_W'(1)) begin
              idx_n   = idx + CNT_W'(1);
              state_n = START;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 3'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = idx_n[0];
      PARITY:  txd_n = par_bit;
      default: txd_n = 1'b1;
    endcase
    rts_n  = (state_n != IDLE);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      idx     <= '0;
      txd     <= 1'b1;
      rts     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      idx     <= idx_n;
      txd     <= txd_n;
      rts     <= rts_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Configuration is frozen for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cfg_q <= '{baud_sel: baud_sel, data_bits: data_bits, stop2: stop2,
                 parity_en: parity_en, parity_odd: parity_odd};
      len_q <= burst_len;
    end
  end

endmodule

// File: tb/tb_uart_burst_tx.sv
// Directed self-checking bench for uart_burst_tx at a scaled-down clock (DIV 40 / 10).
module tb_uart_burst_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, baud_sel, stop2, parity_en, parity_odd;
  logic [1:0] data_bits;
  logic [3:0] burst_len;
  logic       rts, txd, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_burst_tx #(
    .CLK_HZ(96000), .BAUD_LO(2400), .BAUD_HI(9600), .CNT_W(4), .RTS_LEAD(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .baud_sel(baud_sel), .data_bits(data_bits),
    .stop2(stop2), .parity_en(parity_en), .parity_odd(parity_odd), .burst_len(burst_len),
    .rts(rts), .txd(txd), .busy(busy), .done(done)
  );

  task automatic set_cfg(input logic bs, input logic [1:0] db, input logic s2,
                         input logic pe, input logic po, input logic [3:0] bl);
    baud_sel = bs; data_bits = db; stop2 = s2; parity_en = pe; parity_odd = po; burst_len = bl;
  endtask

  // Raises start, then records the line: one txd sample per bit mid-point while rts is high.
  task automatic capture(input int p, input int drop_at, input int rep_hi, input int rep_lo,
                         input int cfg_at, output logic [63:0] seen, output int nb,
                         output int rise, output int len, output int dones,
                         output int busy_err, output int post_rts);
    seen = '0; nb = 0; rise = 0; len = 0; dones = 0; busy_err = 0; post_rts = 0;
    @(posedge clk); #1;
    start = 1'b1;
    while (rts !== 1'b1 && rise < 20) begin
      @(posedge clk); #1;
      rise++;
    end
    if (rts === 1'b1) begin
      int k = 0;
      while (rts === 1'b1 && k < 4000) begin
        if (k == drop_at) start = 1'b0;
        if (k == rep_hi) start = 1'b1;
        if (k == rep_lo) start = 1'b0;
        if (k == cfg_at) set_cfg(~baud_sel, 2'd0, ~stop2, ~parity_en, ~parity_odd, 4'd5);
        if (k % p == p / 2) begin
          seen = {seen[62:0], txd};
          nb++;
        end
        if (done === 1'b1) dones++;
        if (busy !== 1'b1) busy_err++;
        @(posedge clk); #1;
        k++;
      end
      len = k;
      if (done === 1'b1) dones++;
      if (busy !== 1'b0) busy_err++;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1) dones++;
        if (rts === 1'b1) post_rts++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b0;
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1)  begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (rts !== 1'b0)  begin failures++; $display("FAIL reset_rts got=%b exp=0", rts); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic;
    logic [63:0] seen, exp_bits;
    int nb, rise, len, dones, berr, post;
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2);
    exp_bits = 64'(19'b1_0_0000000_1_0_1111111_1);
    capture(10, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (rise !== 3) begin failures++; $display("FAIL basic_rts_latency got=%0d exp=3", rise); end
    checks++; if (nb !== 19 || seen !== exp_bits)
      begin failures++; $display("FAIL basic_txd got=%0d:%h exp=19:%h", nb, seen, exp_bits); end
    checks++; if (len !== 190) begin failures++; $display("FAIL basic_rts_len got=%0d exp=190", len); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", dones); end
    checks++; if (berr !== 0) begin failures++; $display("FAIL basic_busy got=%0d exp=0", berr); end
  endtask

  task automatic test_options;
    logic [63:0] seen, exp_bits;
    int nb, rise, len, dones, berr, post;
    set_cfg(1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 4'd3);
    exp_bits = 64'(37'b1_0_00000000_0_11_0_11111111_0_11_0_00000000_0_11);
    capture(10, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 37 || seen !== exp_bits)
      begin failures++; $display("FAIL even_par_txd got=%0d:%h exp=37:%h", nb, seen, exp_bits); end
    checks++; if (len !== 370) begin failures++; $display("FAIL even_par_len got=%0d exp=370", len); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL even_par_done got=%0d exp=1", dones); end
    set_cfg(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'd3);
    exp_bits = 64'(37'b1_0_00000000_1_11_0_11111111_1_11_0_00000000_1_11);
    capture(10, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 37 || seen !== exp_bits)
      begin failures++; $display("FAIL odd_par_txd got=%0d:%h exp=37:%h", nb, seen, exp_bits); end
    checks++; if (len !== 370) begin failures++; $display("FAIL odd_par_len got=%0d exp=370", len); end
  endtask

  task automatic test_baud_sel;
    logic [63:0] seen, exp_bits;
    int nb, rise, len, dones, berr, post;
    set_cfg(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1);
    exp_bits = 64'(8'b1_0_00000_1);
    capture(40, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 8 || seen !== exp_bits)
      begin failures++; $display("FAIL slow_txd got=%0d:%h exp=8:%h", nb, seen, exp_bits); end
    checks++; if (len !== 320) begin failures++; $display("FAIL slow_rts_len got=%0d exp=320", len); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL slow_done got=%0d exp=1", dones); end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] seen, exp_bits;
    int nb, rise, len, dones, berr, post;
    exp_bits = 64'(19'b1_0_0000000_1_0_1111111_1);
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2);
    capture(10, 50, 80, 100, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 19 || seen !== exp_bits || len !== 190)
      begin failures++; $display("FAIL restart_txd got=%0d:%h len=%0d exp=19:%h len=190", nb, seen, len, exp_bits); end
    checks++; if (dones !== 1 || post !== 0)
      begin failures++; $display("FAIL restart_done got=%0d post_rts=%0d exp=1 0", dones, post); end
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2);
    capture(10, 0, -1, -1, 40, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 19 || seen !== exp_bits || len !== 190)
      begin failures++; $display("FAIL cfg_change got=%0d:%h len=%0d exp=19:%h len=190", nb, seen, len, exp_bits); end
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0);
    capture(10, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    start = 1'b0;
    checks++; if (rise !== 20 || len !== 0)
      begin failures++; $display("FAIL zero_len_rts got=rise%0d len%0d exp=no rts", rise, len); end
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin failures++; $display("FAIL zero_len_status got=busy%b done%b exp=00", busy, done); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] seen, exp_bits;
    int nb, rise, len, dones, berr, post, k;
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2);
    @(posedge clk); #1;
    start = 1'b1;
    k = 0;
    while (rts !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    start = 1'b0;
    repeat (130) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1 || rts !== 1'b1)
      begin failures++; $display("FAIL pre_reset_char1 got=txd%b rts%b exp=11", txd, rts); end
    #2 rst = 1'b0;
    #1;
    checks++; if (txd !== 1'b1 || rts !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL mid_reset got=txd%b rts%b busy%b exp=100", txd, rts, busy); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    exp_bits = 64'(19'b1_0_0000000_1_0_1111111_1);
    capture(10, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 19 || seen !== exp_bits || dones !== 1)
      begin failures++; $display("FAIL post_reset got=%0d:%h done=%0d exp=19:%h done=1", nb, seen, dones, exp_bits); end
  endtask

  task automatic test_held_start;
    logic [63:0] seen, exp_bits;
    int nb, rise, len, dones, berr, post, extra;
    set_cfg(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'd2);
    exp_bits = 64'(19'b1_0_0000000_1_0_1111111_1);
    capture(10, -1, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    extra = post;
    for (int i = 0; i < 780; i++) begin
      @(posedge clk); #1;
      if (rts === 1'b1) extra++;
    end
    checks++; if (nb !== 19 || seen !== exp_bits || dones !== 1)
      begin failures++; $display("FAIL held_first got=%0d:%h done=%0d exp=19:%h done=1", nb, seen, dones, exp_bits); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL held_single got=%0d exp=0", extra); end
    start = 1'b0;
    repeat (5) @(posedge clk);
    capture(10, 0, -1, -1, -1, seen, nb, rise, len, dones, berr, post);
    checks++; if (nb !== 19 || seen !== exp_bits || len !== 190)
      begin failures++; $display("FAIL held_second got=%0d:%h len=%0d exp=19:%h len=190", nb, seen, len, exp_bits); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_options;
    test_baud_sel;
    test_busy_ignore;
    test_reset_mid;
    test_held_start;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
